// File: rtl/multi_dataflow_roberts_mdc_engine_adapter.sv
// Engine-side adapter for the Roberts MDC kernel: gates the source streams into the kernel
// and registers the kernel out_pel stream toward the sink, stopping after cnt_limit beats.
module multi_dataflow_roberts_mdc_engine_adapter #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CNT_WIDTH  = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  clear_i,
   input  logic                  enable_i,
   input  logic                  start_i,
   input  logic [CNT_WIDTH-1:0]  cnt_limit_i,
   output logic                  ready_o,
   output logic                  done_o,
   output logic [CNT_WIDTH-1:0]  cnt_out_pel_o,
   input  logic                  in_pel_valid_i,
   output logic                  in_pel_ready_o,
   input  logic [DATA_WIDTH-1:0] in_pel_data_i,
   input  logic                  in_size_valid_i,
   output logic                  in_size_ready_o,
   input  logic [DATA_WIDTH-1:0] in_size_data_i,
   output logic                  k_in_pel_valid_o,
   input  logic                  k_in_pel_ready_i,
   output logic [DATA_WIDTH-1:0] k_in_pel_data_o,
   output logic                  k_in_size_valid_o,
   input  logic                  k_in_size_ready_i,
   output logic [DATA_WIDTH-1:0] k_in_size_data_o,
   input  logic                  k_out_pel_valid_i,
   output logic                  k_out_pel_ready_o,
   input  logic [DATA_WIDTH-1:0] k_out_pel_data_i,
   output logic                  out_pel_valid_o,
   input  logic                  out_pel_ready_i,
   output logic [DATA_WIDTH-1:0] out_pel_data_o
);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e                state_q;
   logic                  done_q;
   logic [CNT_WIDTH-1:0]  cnt_q;
   logic [CNT_WIDTH-1:0]  acc_q;
   logic [CNT_WIDTH-1:0]  limit_q;
   logic                  valid_q;
   logic [DATA_WIDTH-1:0] data_q;

   logic run;
   logic k_out_ready;
   logic k_hs;
   logic sink_hs;
   logic last_hs;

   always_comb begin
      run         = (state_q == StRun);
      // Accept a kernel beat only while the job still needs beats and the slot is free or draining
      k_out_ready = run & enable_i & (acc_q < limit_q) & (~valid_q | out_pel_ready_i);
      k_hs        = k_out_ready & k_out_pel_valid_i;
      sink_hs     = run & enable_i & valid_q & out_pel_ready_i;
      last_hs     = sink_hs & ((cnt_q + CNT_WIDTH'(1)) == limit_q);
   end

   assign ready_o           = ~run;
   assign done_o            = done_q;
   assign cnt_out_pel_o     = cnt_q;

   assign k_in_pel_valid_o  = run & enable_i & in_pel_valid_i;
   assign in_pel_ready_o    = run & enable_i & k_in_pel_ready_i;
   assign k_in_pel_data_o   = in_pel_data_i;
   assign k_in_size_valid_o = run & enable_i & in_size_valid_i;
   assign in_size_ready_o   = run & enable_i & k_in_size_ready_i;
   assign k_in_size_data_o  = in_size_data_i;

   assign k_out_pel_ready_o = k_out_ready;
   assign out_pel_valid_o   = valid_q;
   assign out_pel_data_o    = data_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         done_q  <= 1'b0;
         cnt_q   <= '0;
         acc_q   <= '0;
         limit_q <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (clear_i) begin
         // Soft reset drops any registered beat but keeps the data bits
         state_q <= StIdle;
         done_q  <= 1'b0;
         cnt_q   <= '0;
         acc_q   <= '0;
         limit_q <= '0;
         valid_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start_i) begin
                  if (cnt_limit_i != '0) begin
                     limit_q <= cnt_limit_i;
                     cnt_q   <= '0;
                     acc_q   <= '0;
                     state_q <= StRun;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            StRun: begin
               if (k_hs) begin
                  data_q  <= k_out_pel_data_i;
                  valid_q <= 1'b1;
                  acc_q   <= acc_q + CNT_WIDTH'(1);
               end else if (sink_hs) begin
                  valid_q <= 1'b0;
               end
               if (sink_hs) begin
                  cnt_q <= cnt_q + CNT_WIDTH'(1);
               end
               if (last_hs) begin
                  state_q <= StIdle;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
